// File: rtl/transform_pkg.sv
// Shared types and sizing for the transform front end.
// Holds fixed-point widths, memory depths and the model reader FSM states.
package transform_pkg;

   localparam int DATAWIDTH          = 24;
   localparam int FRACBITS           = 13;
   localparam int MAX_VERTEX_COUNT   = 16384;
   localparam int MAX_TRIANGLE_COUNT = 16384;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEND_MVP = 3'd1,
      STREAM   = 3'd2,
      SERVE    = 3'd3,
      DONE     = 3'd4
   } reader_state_t;

endpackage

// File: rtl/model_ram.sv
// Single-port-write, single-port-read synchronous RAM, read-first.
// Ports: clk, rstn (clears read register only), we/waddr/wdata, re/raddr/rdata.
module model_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Array has no reset so contents survive a pass abort.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Non-blocking read of the old word gives read-first behaviour.
   always_ff @(posedge clk) begin
      if (!rstn)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/model_reader.sv
// Streams model vertices to the vertex shader and serves triangle indices.
// Ports: start/num/mvp in, mvp out, vertex stream, index port, host writes, busy/done.
module model_reader #(
   parameter int DATAWIDTH          = transform_pkg::DATAWIDTH,
   parameter int MAX_VERTEX_COUNT   = transform_pkg::MAX_VERTEX_COUNT,
   parameter int MAX_TRIANGLE_COUNT = transform_pkg::MAX_TRIANGLE_COUNT,
   localparam int AW = $clog2(MAX_VERTEX_COUNT),
   localparam int TW = $clog2(MAX_TRIANGLE_COUNT)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [AW-1:0]           i_num_vertices,
   input  logic [16*DATAWIDTH-1:0] i_mvp_matrix,
   output logic [16*DATAWIDTH-1:0] o_mvp_matrix,
   output logic                    o_mvp_dv,
   input  logic                    i_vertex_ready,
   output logic [3*DATAWIDTH-1:0]  o_vertex,
   output logic                    o_vertex_dv,
   output logic                    o_vertex_last,
   input  logic [TW-1:0]           i_index_buff_addr,
   input  logic                    i_index_buff_read_en,
   output logic [3*AW-1:0]         o_vertex_idxs,
   input  logic                    i_vtx_wr_en,
   input  logic [AW-1:0]           i_vtx_wr_addr,
   input  logic [3*DATAWIDTH-1:0]  i_vtx_wr_data,
   input  logic                    i_idx_wr_en,
   input  logic [TW-1:0]           i_idx_wr_addr,
   input  logic [3*AW-1:0]         i_idx_wr_data,
   input  logic                    i_pipeline_finished,
   output logic                    o_busy,
   output logic                    o_done
);

   import transform_pkg::*;

   localparam logic [AW-1:0] ONE = AW'(1);

   reader_state_t state, state_nx;

   logic [AW-1:0] cnt;
   logic [AW-1:0] num;
   logic          accept;
   logic          rd;
   logic          dv;
   logic          last;
   logic          guard;

   assign accept = (state == IDLE) && start
                   && (i_num_vertices != '0);

   // dv doubles as the read-pending flag; guard blocks the cycle after it.
   assign rd = (state == STREAM) && !dv && !guard
               && i_vertex_ready;

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (accept) state_nx = SEND_MVP;
         SEND_MVP: state_nx = STREAM;
         STREAM:   if (dv && last) state_nx = SERVE;
         SERVE:    if (i_pipeline_finished) state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_mvp_dv = 1'b0;
      o_done   = 1'b0;
      o_busy   = 1'b1;
      unique case (state)
         IDLE:     o_busy   = 1'b0;
         SEND_MVP: o_mvp_dv = 1'b1;
         DONE:     o_done   = 1'b1;
         default:  o_busy   = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt          <= '0;
         num          <= '0;
         dv           <= 1'b0;
         last         <= 1'b0;
         guard        <= 1'b0;
         o_mvp_matrix <= '0;
      end else begin
         dv    <= rd;
         last  <= rd && (cnt == num - ONE);
         guard <= dv;
         if (accept) begin
            num          <= i_num_vertices;
            cnt          <= '0;
            o_mvp_matrix <= i_mvp_matrix;
         end else if (dv) begin
            cnt <= cnt + ONE;
         end
      end
   end

   assign o_vertex_dv   = dv;
   assign o_vertex_last = last;

   model_ram #(
      .WIDTH (3*DATAWIDTH),
      .DEPTH (MAX_VERTEX_COUNT)
   ) u_vtx_ram (
      .clk   (clk),
      .rstn  (rstn),
      .we    (i_vtx_wr_en && !o_busy),
      .waddr (i_vtx_wr_addr),
      .wdata (i_vtx_wr_data),
      .re    (rd),
      .raddr (cnt),
      .rdata (o_vertex)
   );

   model_ram #(
      .WIDTH (3*AW),
      .DEPTH (MAX_TRIANGLE_COUNT)
   ) u_idx_ram (
      .clk   (clk),
      .rstn  (rstn),
      .we    (i_idx_wr_en && !o_busy),
      .waddr (i_idx_wr_addr),
      .wdata (i_idx_wr_data),
      .re    (i_index_buff_read_en),
      .raddr (i_index_buff_addr),
      .rdata (o_vertex_idxs)
   );

endmodule
